master_port: RTL and testbench

Master-side bus interface that sits directly upstream of the bus arbiter and drives one of its master ports (m1 or m2). Converts a parallel local transaction request (slave select, memory address, write/read, optional burst) into the arbiter's serial request / address / data / valid protocol. Returns read data as parallel words. Pauses and resumes cleanly when the arbiter hands the bus to the other master mid-transaction (split).

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_shift_reg.sv | 36 +++
 rtl/master_port.sv | 173 +++++++++++++++++
 tb/tb_master_port.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus definitions: FSM states, slave-select codes and a sizing helper
// used by the master port, arbiter and slave ports.
package bus_pkg;

  localparam int SSEL_WIDTH = 2;

  typedef enum logic [SSEL_WIDTH-1:0] {
    SLV_S1      = 2'd0,
    SLV_S2      = 2'd1,
    SLV_S3      = 2'd2,
    SLV_ILLEGAL = 2'd3
  } slave_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_SSEL,
    ST_WAIT_RDY,
    ST_ADDR,
    ST_WDATA,
    ST_RDATA,
    ST_DONE
  } state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bus_shift_reg.sv
// Parallel-load shift register with selectable shift direction and hold.
// Load has priority over shift; with neither asserted the contents hold.
module bus_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         shift_en,
  input  logic         msb_first,
  input  logic         shift_in,
  output logic [W-1:0] q,
  output logic         ser_out
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (shift_en) begin
      q_d = msb_first ? {q_q[W-2:0], shift_in} : {shift_in, q_q[W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q       = q_q;
  assign ser_out = msb_first ? q_q[W-1] : q_q[0];

endmodule

// File: rtl/master_port.sv
// Master-side bus port: serialises a parallel request into the arbiter's
// request/address/data/valid protocol and collects read words; stalls on split.
module master_port
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  write,
  input  logic [1:0]            slave_sel,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [LEN_WIDTH-1:0]  burst_len,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ack,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  m_request,
  output logic                  m_address_valid,
  output logic                  m_address,
  output logic                  m_data,
  output logic                  m_valid,
  output logic                  m_write_en,
  output logic                  m_burst,
  input  logic                  m_ready,
  input  logic                  m_available,
  input  logic                  m_data_out,
  input  logic                  m_valid_in
);

  localparam int TXW = max_int(ADDR_WIDTH, DATA_WIDTH);
  localparam int BW  = $clog2(TXW + 1);

  state_e                state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [LEN_WIDTH-1:0]  word_q, word_d;
  logic [1:0]            sel_q, sel_d;
  logic                  write_q, write_d, burst_q, burst_d, addr_sent_q, addr_sent_d;
  logic                  wdata_ack_q, wdata_ack_d, rdata_valid_q, rdata_valid_d;
  logic                  done_q, done_d, error_q, error_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  tx_load, tx_shift, tx_ser, rx_shift, word_end;
  logic [TXW-1:0]        tx_load_val, tx_par_unused;
  logic [DATA_WIDTH-2:0] rx_q;
  logic                  rx_ser_unused;

  // Address is left-aligned so the MSB-first shift reaches it first; data is LSB-aligned.
  bus_shift_reg #(.W(TXW)) u_tx (
    .clk(clk), .rst(reset), .load(tx_load), .load_val(tx_load_val),
    .shift_en(tx_shift), .msb_first(state_q == ST_ADDR), .shift_in(1'b0),
    .q(tx_par_unused), .ser_out(tx_ser)
  );

  // Holds the first DATA_WIDTH-1 bits; the final bit is merged straight into rdata.
  bus_shift_reg #(.W(DATA_WIDTH-1)) u_rx (
    .clk(clk), .rst(reset), .load(1'b0), .load_val('0),
    .shift_en(rx_shift), .msb_first(1'b0), .shift_in(m_data_out),
    .q(rx_q), .ser_out(rx_ser_unused)
  );

  always_comb begin
    state_d = state_q;  bit_d = bit_q;  word_d = word_q;
    sel_d = sel_q;  write_d = write_q;  burst_d = burst_q;  addr_sent_d = addr_sent_q;
    wdata_ack_d = 1'b0;  rdata_valid_d = 1'b0;  done_d = 1'b0;  error_d = 1'b0;
    rdata_d = rdata_q;
    tx_load = 1'b0;  tx_load_val = TXW'(wdata);  tx_shift = 1'b0;  rx_shift = 1'b0;
    word_end = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start && slave_sel == SLV_ILLEGAL) begin
          error_d = 1'b1;
        end else if (start) begin
          state_d = ST_REQ;  sel_d = slave_sel;  write_d = write;
          burst_d = (burst_len != '0);  word_d = burst_len;  bit_d = '0;
          addr_sent_d = 1'b0;
          tx_load = 1'b1;  tx_load_val = TXW'(mem_addr) << (TXW - ADDR_WIDTH);
        end
      end
      ST_REQ: if (m_available) begin
        state_d = ST_SSEL;  bit_d = '0;
      end
      ST_SSEL: if (m_available) begin
        if (bit_q == BW'(SSEL_WIDTH)) begin
          bit_d = '0;  state_d = ST_WAIT_RDY;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_WAIT_RDY: if (m_ready) begin
        bit_d = '0;
        if (!addr_sent_q)  state_d = ST_ADDR;
        else if (write_q) begin
          state_d = ST_WDATA;  tx_load = 1'b1;
        end else           state_d = ST_RDATA;
      end
      ST_ADDR: if (m_available) begin
        tx_shift = 1'b1;
        if (bit_q == BW'(ADDR_WIDTH - 1)) begin
          bit_d = '0;  addr_sent_d = 1'b1;
          if (write_q) begin
            state_d = ST_WDATA;  tx_load = 1'b1;
          end else     state_d = ST_RDATA;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_WDATA: if (m_available) begin
        tx_shift = 1'b1;
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          wdata_ack_d = 1'b1;  word_end = 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      ST_RDATA: if (m_available && m_valid_in) begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          rdata_d = {m_data_out, rx_q};  rdata_valid_d = 1'b1;  word_end = 1'b1;
        end else begin
          rx_shift = 1'b1;  bit_d = bit_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (word_end) begin
      bit_d = '0;
      if (word_q == '0) begin
        state_d = ST_DONE;  done_d = 1'b1;
      end else begin
        word_d = word_q - 1'b1;  state_d = ST_WAIT_RDY;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;  bit_q <= '0;  word_q <= '0;  sel_q <= '0;
      write_q <= 1'b0;  burst_q <= 1'b0;  addr_sent_q <= 1'b0;
      wdata_ack_q <= 1'b0;  rdata_valid_q <= 1'b0;  done_q <= 1'b0;  error_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;  bit_q <= bit_d;  word_q <= word_d;  sel_q <= sel_d;
      write_q <= write_d;  burst_q <= burst_d;  addr_sent_q <= addr_sent_d;
      wdata_ack_q <= wdata_ack_d;  rdata_valid_q <= rdata_valid_d;
      done_q <= done_d;  error_q <= error_d;  rdata_q <= rdata_d;
    end
  end

  assign busy            = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign m_request       = busy;
  assign m_address_valid = (state_q == ST_REQ);
  assign m_write_en      = busy && write_q;
  assign m_burst         = busy && burst_q;
  assign m_valid         = m_available &&
                           (state_q == ST_SSEL || state_q == ST_ADDR || state_q == ST_WDATA);
  // Slave select goes out as sel[1], sel[1], sel[0] to suit the arbiter's capture.
  assign m_address       = (state_q == ST_SSEL) ? ((bit_q == BW'(SSEL_WIDTH)) ? sel_q[0] : sel_q[1])
                         : (state_q == ST_ADDR) ? tx_ser : 1'b0;
  assign m_data          = (state_q == ST_WDATA) && tx_ser;
  assign wdata_ack       = wdata_ack_q;
  assign rdata_valid     = rdata_valid_q;
  assign done            = done_q;
  assign error           = error_q;
  assign rdata           = rdata_q;

endmodule

// File: tb/tb_master_port.sv
// Directed bench for master_port: vector table of single transactions plus
// hand-written burst, split, busy-start and asynchronous-reset sequences.
module tb_master_port;

  logic        clk = 1'b0;
  logic        reset, start, write;
  logic [1:0]  slave_sel;
  logic [11:0] mem_addr;
  logic [3:0]  burst_len;
  logic [7:0]  wdata;
  logic        wdata_ack, rdata_valid, busy, done, error;
  logic [7:0]  rdata;
  logic        m_request, m_address_valid, m_address, m_data, m_valid, m_write_en, m_burst;
  logic        m_ready, m_available, m_data_out, m_valid_in;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  master_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8), .LEN_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .write(write), .slave_sel(slave_sel),
    .mem_addr(mem_addr), .burst_len(burst_len), .wdata(wdata), .wdata_ack(wdata_ack),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .error(error),
    .m_request(m_request), .m_address_valid(m_address_valid), .m_address(m_address),
    .m_data(m_data), .m_valid(m_valid), .m_write_en(m_write_en), .m_burst(m_burst),
    .m_ready(m_ready), .m_available(m_available), .m_data_out(m_data_out),
    .m_valid_in(m_valid_in)
  );

  typedef struct {
    string       name;
    logic        wr;
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [7:0]  dat;       // write word, or word the slave returns on a read
    logic [2:0]  exp_ssel;  // slave-select bits in wire order
    logic        exp_err;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [19:0] all_outs();
    return {busy, done, error, wdata_ack, rdata_valid, m_request, m_address_valid,
            m_address, m_data, m_valid, m_write_en, m_burst, rdata};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic wr, input logic [1:0] sel, input logic [11:0] addr,
                        input logic [3:0] blen);
    write = wr;  slave_sel = sel;  mem_addr = addr;  burst_len = blen;  start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic [2:0]  ssel_got;
    logic [11:0] addr_got;
    logic [7:0]  d_got;
    int          bad_valid, early;
    ssel_got = '0;  addr_got = '0;  d_got = '0;  bad_valid = 0;  early = 0;
    wdata = v.wr ? v.dat : 8'h00;
    launch(v.wr, v.sel, v.addr, 4'd0);
    if (v.exp_err) begin
      chk({v.name, " err_pulse"}, {error, m_request, busy}, 3'b100);
      tick();
      chk({v.name, " err_width"}, {error, m_request}, 2'b00);
      return;
    end
    chk({v.name, " req"}, {m_request, m_address_valid, m_write_en, m_burst, error},
        {3'b110 | {2'b00, v.wr}, 2'b00});
    tick();
    for (int i = 0; i < 3; i++) begin
      if (!m_valid) bad_valid++;
      ssel_got = {ssel_got[1:0], m_address};
      tick();
    end
    chk({v.name, " ssel"}, ssel_got, v.exp_ssel);
    chk({v.name, " wait_rdy"}, {m_valid, m_request}, 2'b01);
    tick();
    for (int i = 0; i < 12; i++) begin
      if (!m_valid) bad_valid++;
      addr_got = {addr_got[10:0], m_address};
      early += int'(done | wdata_ack | rdata_valid);
      tick();
    end
    chk({v.name, " addr"}, addr_got, v.addr);
    for (int i = 0; i < 8; i++) begin
      if (v.wr) begin
        if (!m_valid) bad_valid++;
        d_got[i] = m_data;
      end else begin
        if (m_valid) bad_valid++;
        m_valid_in = 1'b1;
        m_data_out = v.dat[i];
      end
      early += int'(done | wdata_ack | rdata_valid);
      tick();
    end
    m_valid_in = 1'b0;
    chk({v.name, " valid_shape"}, bad_valid, 0);
    chk({v.name, " no_early_pulse"}, early, 0);
    if (v.wr) begin
      chk({v.name, " wdata"}, d_got, v.dat);
      chk({v.name, " ack_done"}, {wdata_ack, done, busy, m_request}, 4'b1100);
    end else begin
      chk({v.name, " rdata"}, rdata, v.dat);
      chk({v.name, " rvalid_done"}, {rdata_valid, done, busy, m_request}, 4'b1100);
    end
    tick();
    chk({v.name, " pulses_end"}, {wdata_ack, rdata_valid, done, busy}, 4'b0000);
  endtask

  task automatic seq_burst();
    logic [7:0]  words[3];
    logic [23:0] dbits;
    int vcnt, acks, stall, stall_viol, burst_viol, seen;
    words[0] = 8'h11;  words[1] = 8'h22;  words[2] = 8'h33;
    dbits = '0;  vcnt = 0;  acks = 0;  stall = 0;  stall_viol = 0;  burst_viol = 0;  seen = 0;
    wdata = words[0];
    launch(1'b1, 2'd2, 12'h123, 4'd2);
    for (int cyc = 0; cyc < 300; cyc++) begin
      #1;
      if (m_request && !m_burst) burst_viol++;
      if (stall > 0) begin
        if (m_valid) stall_viol++;
        stall--;
        if (stall == 0) m_ready = 1'b1;
      end
      if (m_valid) begin
        if (vcnt >= 15 && vcnt < 39) dbits[vcnt-15] = m_data;
        vcnt++;
      end
      if (wdata_ack) begin
        acks++;
        if (acks < 3) begin
          wdata = words[acks];
          m_ready = 1'b0;
          stall = 4;
        end
      end
      if (done) begin
        seen = 1;
        break;
      end
      tick();
    end
    m_ready = 1'b1;
    chk("burst done_seen", seen, 1);
    chk("burst ack_count", acks, 3);
    chk("burst valid_cycles", vcnt, 39);
    chk("burst m_burst_held", burst_viol, 0);
    chk("burst stall_honoured", stall_viol, 0);
    chk("burst word0", dbits[7:0], 8'h11);
    chk("burst word1", dbits[15:8], 8'h22);
    chk("burst word2", dbits[23:16], 8'h33);
    tick();
  endtask

  task automatic seq_split();
    logic [7:0] d_got;
    int vcnt, gap, gap_seen, gap_viol, seen;
    d_got = '0;  vcnt = 0;  gap = 0;  gap_seen = 0;  gap_viol = 0;  seen = 0;
    wdata = 8'hA5;
    launch(1'b1, 2'd0, 12'h5A5, 4'd0);
    for (int cyc = 0; cyc < 200; cyc++) begin
      m_available = (gap > 0) ? 1'b0 : 1'b1;
      #1;
      if (gap > 0) begin
        if (m_valid || !m_request) gap_viol++;
        gap_seen++;
        gap--;
      end else if (m_valid) begin
        if (vcnt >= 15 && vcnt < 23) d_got[vcnt-15] = m_data;
        vcnt++;
        if (vcnt == 19) gap = 5;
      end
      if (done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    m_available = 1'b1;
    chk("split done_seen", seen, 1);
    chk("split gap_cycles", gap_seen, 5);
    chk("split gap_quiet", gap_viol, 0);
    chk("split data_resumed", d_got, 8'hA5);
    chk("split valid_cycles", vcnt, 23);
    tick();
  endtask

  task automatic seq_busy_reset();
    launch(1'b1, 2'd2, 12'h123, 4'd0);
    write = 1'b0;  slave_sel = 2'd3;  start = 1'b1;  // start while busy, illegal select
    tick();
    start = 1'b0;
    chk("busy_start ignored", {error, m_request, m_valid, busy}, 4'b0111);
    for (int i = 0; i < 6; i++) tick();
    chk("reset_mid in_addr", {m_valid, m_request, m_write_en}, 3'b111);
    #2 reset = 1'b1;
    #1 chk("reset_mid async_zero", all_outs(), 20'h0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("reset_mid idle_after", all_outs(), 20'h0);
  endtask

  initial begin
    reset = 1'b1;  start = 1'b0;  write = 1'b0;  slave_sel = '0;  mem_addr = '0;
    burst_len = '0;  wdata = '0;
    m_ready = 1'b1;  m_available = 1'b1;  m_data_out = 1'b0;  m_valid_in = 1'b0;

    vecs[0] = '{"wr_s1",  1'b1, 2'd1, 12'h0A5, 8'h3C, 3'b001, 1'b0};
    vecs[1] = '{"rd_s2",  1'b0, 2'd2, 12'h3F0, 8'h96, 3'b110, 1'b0};
    vecs[2] = '{"wr_s0",  1'b1, 2'd0, 12'hFFF, 8'hA5, 3'b000, 1'b0};
    vecs[3] = '{"illegal",1'b1, 2'd3, 12'h001, 8'h00, 3'b000, 1'b1};
    vecs[4] = '{"rd_s1",  1'b0, 2'd1, 12'h800, 8'h01, 3'b001, 1'b0};

    tick();
    chk("reset outputs", all_outs(), 20'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("idle outputs", all_outs(), 20'h0);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);
    seq_burst();
    seq_split();
    seq_busy_reset();
    run_txn(vecs[0]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
